// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg: shared 1024x768@60 timing constants and coordinate type
// Ports: none (package vgaPkg).
package vgaPkg;
   localparam int HACTIVE = 1024;
   localparam int HFP     = 24;
   localparam int HSYNC_W = 136;
   localparam int HBP     = 160;
   localparam int VACTIVE = 768;
   localparam int VFP     = 3;
   localparam int VSYNC_W = 6;
   localparam int VBP     = 29;
   localparam int HTOTAL  = HACTIVE + HFP + HSYNC_W + HBP;
   localparam int VTOTAL  = VACTIVE + VFP + VSYNC_W + VBP;
   typedef logic [10:0] coord_t;
endpackage

// File: rtl/vga_if.sv
// vga_if: pixel pipeline bundle carrying counts, syncs, blanking and colour
// Ports: modport out (producer), modport in (consumer).
interface vga_if;
   import vgaPkg::*;
   coord_t      hcount, vcount;
   logic        hsync, hblnk, vsync, vblnk;
   logic [11:0] rgb;
   modport out(output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
   modport in(input hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (count, sync, blank) with wrap strobe
// Ports: clk, rst (sync, active-high), inc (advance), count, sync, blnk (registered), wrap (inc at last position).
import vgaPkg::*;
module vga_axis_counter #(
   parameter int ACTIVE = 1024,
   parameter int FP     = 24,
   parameter int SYNC_W = 136,
   parameter int BP     = 160
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   inc,
   output coord_t count,
   output logic   sync,
   output logic   blnk,
   output logic   wrap
);
   localparam int TOTAL = ACTIVE + FP + SYNC_W + BP;
   coord_t nxt;
   assign wrap = inc && count == coord_t'(TOTAL - 1);
   assign nxt  = wrap ? '0 : inc ? count + 1'b1 : count;
   // Flags decode nxt so they line up with the count they describe.
   always_ff @(posedge clk)
      if (rst) begin
         count <= '0;
         sync  <= 1'b0;
         blnk  <= 1'b0;
      end else begin
         count <= nxt;
         blnk  <= nxt >= coord_t'(ACTIVE);
         sync  <= nxt >= coord_t'(ACTIVE + FP) && nxt < coord_t'(ACTIVE + FP + SYNC_W);
      end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing source with frame strobe and animation toggle
// Ports: clk, rst (sync, active-high), enable (0 freezes everything),
//        frame_start (pulse at (0,0)), animation (toggles every ANIM_FRAMES frames),
//        out (vga_if producer: counts, active-high syncs, blanking, rgb=0).
module vga_timing_gen #(
   parameter int HACTIVE     = vgaPkg::HACTIVE,
   parameter int HFP         = vgaPkg::HFP,
   parameter int HSYNC_W     = vgaPkg::HSYNC_W,
   parameter int HBP         = vgaPkg::HBP,
   parameter int VACTIVE     = vgaPkg::VACTIVE,
   parameter int VFP         = vgaPkg::VFP,
   parameter int VSYNC_W     = vgaPkg::VSYNC_W,
   parameter int VBP         = vgaPkg::VBP,
   parameter int ANIM_FRAMES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic frame_start,
   output logic animation,
   vga_if.out   out
);
   import vgaPkg::coord_t;
   coord_t     hc, vc;
   logic       hs, hb, vs, vb, h_wrap, v_wrap, started;
   logic [7:0] frame_cnt;
   logic       last;
   // The first enabled edge after reset holds (0,0) so it can carry frame_start.
   vga_axis_counter #(.ACTIVE(HACTIVE), .FP(HFP), .SYNC_W(HSYNC_W), .BP(HBP)) u_h (
      .clk(clk), .rst(rst), .inc(enable && started),
      .count(hc), .sync(hs), .blnk(hb), .wrap(h_wrap));
   vga_axis_counter #(.ACTIVE(VACTIVE), .FP(VFP), .SYNC_W(VSYNC_W), .BP(VBP)) u_v (
      .clk(clk), .rst(rst), .inc(h_wrap),
      .count(vc), .sync(vs), .blnk(vb), .wrap(v_wrap));
   assign last = frame_cnt == 8'(ANIM_FRAMES - 1);
   always_ff @(posedge clk)
      if (rst) begin
         started     <= 1'b0;
         frame_start <= 1'b0;
         animation   <= 1'b0;
         frame_cnt   <= '0;
      end else if (enable) begin
         started     <= 1'b1;
         frame_start <= !started || v_wrap;
         if (v_wrap) begin
            frame_cnt <= last ? '0 : frame_cnt + 1'b1;
            animation <= animation ^ last;
         end
      end else
         frame_start <= 1'b0;
   assign out.hcount = hc;
   assign out.vcount = vc;
   assign out.hsync  = hs;
   assign out.hblnk  = hb;
   assign out.vsync  = vs;
   assign out.vblnk  = vb;
   assign out.rgb    = '0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized self-checking bench against a raster-position model
module tb_vga_timing_gen;
   localparam int HA = 16, HF = 2, HS = 3, HB = 4;
   localparam int VA = 8, VF = 1, VS = 2, VB = 2;
   localparam int AF = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;
   logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
   logic fs, anim, fs1, anim1;
   int   vecs = 0, errs = 0;
   // Model: m_run means the raster is running; t counts enabled edges since the
   // post-reset (0,0) pulse, so position, frame number and animation follow by division.
   bit   m_run = 0, m_fs = 0;
   int   t = 0;
   vga_if vo();
   vga_if vo1();
   vga_timing_gen #(.HACTIVE(HA), .HFP(HF), .HSYNC_W(HS), .HBP(HB), .VACTIVE(VA), .VFP(VF),
      .VSYNC_W(VS), .VBP(VB), .ANIM_FRAMES(AF)) dut (
      .clk(clk), .rst(rst), .enable(enable), .frame_start(fs), .animation(anim), .out(vo));
   vga_timing_gen #(.HACTIVE(HA), .HFP(HF), .HSYNC_W(HS), .HBP(HB), .VACTIVE(VA), .VFP(VF),
      .VSYNC_W(VS), .VBP(VB), .ANIM_FRAMES(1)) dut1 (
      .clk(clk), .rst(rst), .enable(enable), .frame_start(fs1), .animation(anim1), .out(vo1));
   always #5 clk = ~clk;
   wire logic [40:0] act = {vo.hcount, vo.vcount, vo.hsync, vo.hblnk, vo.vsync, vo.vblnk,
                            fs, anim, anim1, vo.rgb};
   function automatic logic [40:0] expv();
      int p = t % FT, h = p % HT, v = p / HT, f = t / FT;
      if (!m_run) return '0;
      return {11'(h), 11'(v), h >= HA + HF && h < HA + HF + HS, h >= HA,
              v >= VA + VF && v < VA + VF + VS, v >= VA, m_fs, 1'((f / AF) % 2),
              1'(f % 2), 12'd0};
   endfunction
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_run = 0; t = 0; m_fs = 0;
      end else if (enable) begin
         if (!m_run) begin m_run = 1; t = 0; end else t++;
         m_fs = (t % FT) == 0;
      end else m_fs = 0;
      @(negedge clk);
   endtask
   task automatic test_reset();
      rst = 1; enable = 1;
      for (int i = 0; i < 3; i++) begin
         tick(); vecs++;
         if (act !== 41'd0) begin errs++; $display("FAIL reset_state got %h exp 0", act); end
      end
      rst = 0;
      tick(); vecs++;
      if (act !== expv() || fs !== 1'b1) begin errs++; $display("FAIL first_frame_start got %h exp %h", act, expv()); end
      tick(); vecs++;
      if (act !== expv() || vo.hcount !== 11'd1 || fs !== 1'b0) begin errs++; $display("FAIL first_count got %h exp %h", act, expv()); end
   endtask
   task automatic test_line();
      for (int i = 0; i < HT + 2; i++) begin
         tick(); vecs++;
         if (act !== expv()) begin errs++; $display("FAIL line t=%0d got %h exp %h", t, act, expv()); end
      end
   endtask
   task automatic test_frames();
      int n = 0, last = -1;
      for (int i = 0; i < 5 * FT; i++) begin
         tick(); n++; vecs++;
         if (act !== expv()) begin errs++; $display("FAIL frame t=%0d got %h exp %h", t, act, expv()); end
         if (fs) begin
            if (last >= 0) begin
               vecs++;
               if (n - last !== FT) begin errs++; $display("FAIL frame_period got %0d exp %0d", n - last, FT); end
            end
            last = n;
         end
      end
   endtask
   task automatic test_freeze();
      int n = 0;
      while ((t % FT) != 5 * HT + 10 && n < 2 * FT) begin
         tick(); n++;
      end
      vecs++;
      if (n >= 2 * FT) begin errs++; $display("FAIL freeze_reach got t=%0d exp pos %0d", t, 5 * HT + 10); end
      enable = 0;
      for (int i = 0; i < 50; i++) begin
         tick(); vecs++;
         if (act !== expv()) begin errs++; $display("FAIL freeze i=%0d got %h exp %h", i, act, expv()); end
      end
      enable = 1;
      tick(); vecs++;
      if (act !== expv() || vo.hcount !== 11'd11 || vo.vcount !== 11'd5) begin errs++; $display("FAIL resume got %h exp %h", act, expv()); end
   endtask
   task automatic test_mid_reset();
      int n = 0;
      while ((t % FT) != 6 * HT + 20 && n < 2 * FT) begin
         tick(); n++;
      end
      vecs++;
      if (n >= 2 * FT) begin errs++; $display("FAIL mid_reach got t=%0d exp pos %0d", t, 6 * HT + 20); end
      rst = 1;
      tick(); vecs++;
      if (act !== 41'd0) begin errs++; $display("FAIL mid_reset got %h exp 0", act); end
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         tick(); vecs++;
         if (act !== expv()) begin errs++; $display("FAIL restart i=%0d got %h exp %h", i, act, expv()); end
      end
   endtask
   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         enable = $urandom_range(0, 9) != 0;
         rst = $urandom_range(0, 599) == 0;
         tick(); vecs++;
         if (act !== expv()) begin errs++; $display("FAIL random i=%0d got %h exp %h", i, act, expv()); end
      end
      rst = 0; enable = 1;
   endtask
   initial begin
      test_reset();
      test_line();
      test_frames();
      test_freeze();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
